chacha20_stream_cipher: RTL

- Sequential ChaCha20 (RFC 7539) keystream engine; the consumer side of the quarter-round primitive.
- Loads a key, nonce and initial counter, then iterates double-rounds to form 64-byte keystream blocks.
- XORs each keystream word onto a 32-bit data stream through valid/ready handshakes.
- The operation is symmetric, so the same block encrypts and decrypts. Sits between the host data path and the link/storage interface.

---
 rtl/chacha20_pkg.sv | 28 ++
 rtl/chacha20_qr.sv | 23 ++
 rtl/chacha20_stream_cipher.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/chacha20_pkg.sv
// chacha20_pkg: shared constants, types and helpers for the ChaCha20 keystream engine
package chacha20_pkg;
   localparam logic [31:0] SIGMA [4] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};
   typedef logic [15:0][31:0] state_t;
   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_ADD, S_STREAM} fsm_e;
   localparam logic [3:0] COL_IDX [4][4] = '{
      '{4'd0, 4'd4, 4'd8,  4'd12},
      '{4'd1, 4'd5, 4'd9,  4'd13},
      '{4'd2, 4'd6, 4'd10, 4'd14},
      '{4'd3, 4'd7, 4'd11, 4'd15}};
   localparam logic [3:0] DIAG_IDX [4][4] = '{
      '{4'd0, 4'd5, 4'd10, 4'd15},
      '{4'd1, 4'd6, 4'd11, 4'd12},
      '{4'd2, 4'd7, 4'd8,  4'd13},
      '{4'd3, 4'd4, 4'd9,  4'd14}};
   function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction
   function automatic state_t load_state(input logic [255:0] key, input logic [95:0] nonce,
                                         input logic [31:0] ctr);
      state_t s;
      for (int i = 0; i < 4; i++) s[i] = SIGMA[i];
      for (int i = 0; i < 8; i++) s[4+i] = key[32*i +: 32];
      s[12] = ctr;
      for (int i = 0; i < 3; i++) s[13+i] = nonce[32*i +: 32];
      return s;
   endfunction
endpackage

// File: rtl/chacha20_qr.sv
// chacha20_qr: combinational ChaCha20 quarter-round
module chacha20_qr
   import chacha20_pkg::*;
(
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic [31:0] i_c,
   input  logic [31:0] i_d,
   output logic [31:0] o_a,
   output logic [31:0] o_b,
   output logic [31:0] o_c,
   output logic [31:0] o_d
);
   logic [31:0] w_a1, w_b1, w_c1, w_d1;
   assign w_a1 = i_a + i_b;
   assign w_d1 = rotl(i_d ^ w_a1, 16);
   assign w_c1 = i_c + w_d1;
   assign w_b1 = rotl(i_b ^ w_c1, 12);
   assign o_a  = w_a1 + w_b1;
   assign o_d  = rotl(w_d1 ^ o_a, 8);
   assign o_c  = w_c1 + o_d;
   assign o_b  = rotl(w_b1 ^ o_c, 7);
endmodule

// File: rtl/chacha20_stream_cipher.sv
// chacha20_stream_cipher: sequential ChaCha20 keystream generator XORed onto a 32-bit valid/ready stream
module chacha20_stream_cipher
   import chacha20_pkg::*;
#(
   parameter int ROUNDS = 20
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_init,
   input  logic [255:0] i_key,
   input  logic [95:0]  i_nonce,
   input  logic [31:0]  i_ctr,
   input  logic         i_in_valid,
   output logic         o_in_ready,
   input  logic [31:0]  i_in_data,
   input  logic         i_in_last,
   output logic         o_out_valid,
   input  logic         i_out_ready,
   output logic [31:0]  o_out_data,
   output logic         o_out_last,
   output logic         o_busy,
   output logic         o_ctr_wrap
);
   localparam int RW = $clog2(ROUNDS);
   fsm_e r_state, w_next;
   state_t r_init, r_work, w_load, w_round, w_sum, w_reload;
   logic [RW-1:0] r_rnd;
   logic [3:0] r_k;
   logic r_out_valid, r_out_last, r_wrap;
   logic [31:0] r_out_data, w_ctr_inc;
   logic w_in_ready, w_in_hs, w_blk_end, w_rnd_last;
   logic [3:0] w_idx [4][4];
   logic [3:0][3:0][31:0] w_qi, w_qo;

   assign w_load     = load_state(i_key, i_nonce, i_ctr);
   assign w_in_hs    = i_in_valid && w_in_ready && !i_init;
   assign w_blk_end  = w_in_hs && r_k == 4'd15 && !i_in_last;
   assign w_rnd_last = r_rnd == RW'(ROUNDS - 1);
   assign w_ctr_inc  = r_init[12] + 32'd1;

   // pick column or diagonal word indices for this round and gather quarter-round inputs
   always_comb begin
      for (int q = 0; q < 4; q++)
         for (int j = 0; j < 4; j++) begin
            w_idx[q][j] = r_rnd[0] ? DIAG_IDX[q][j] : COL_IDX[q][j];
            w_qi[q][j]  = r_work[w_idx[q][j]];
         end
   end

   for (genvar q = 0; q < 4; q++) begin : g_qr
      chacha20_qr u_qr (
         .i_a(w_qi[q][0]), .i_b(w_qi[q][1]), .i_c(w_qi[q][2]), .i_d(w_qi[q][3]),
         .o_a(w_qo[q][0]), .o_b(w_qo[q][1]), .o_c(w_qo[q][2]), .o_d(w_qo[q][3])
      );
   end

   // scatter quarter-round results back to their word positions
   always_comb begin
      w_round = r_work;
      for (int q = 0; q < 4; q++)
         for (int j = 0; j < 4; j++)
            w_round[w_idx[q][j]] = w_qo[q][j];
   end

   // final feed-forward addition and next-block reload with bumped counter
   always_comb begin
      w_sum = '0;
      for (int i = 0; i < 16; i++) w_sum[i] = r_work[i] + r_init[i];
      w_reload     = r_init;
      w_reload[12] = w_ctr_inc;
   end

   // FSM state register
   always_ff @(posedge clk) r_state <= rst ? S_IDLE : w_next;

   // FSM next-state; init restarts from any state
   always_comb begin
      w_next = r_state;
      if (i_init) w_next = S_ROUND;
      else if (r_state == S_ROUND) w_next = w_rnd_last ? S_ADD : S_ROUND;
      else if (r_state == S_ADD) w_next = S_STREAM;
      else if (r_state == S_STREAM && w_in_hs)
         w_next = i_in_last ? S_IDLE : (r_k == 4'd15 ? S_ROUND : S_STREAM);
   end

   // FSM outputs
   always_comb begin
      w_in_ready = r_state == S_STREAM && (!r_out_valid || i_out_ready);
      o_busy     = r_state != S_IDLE;
   end

   // block state, round counter, word index and wrap flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_init <= '0;
         r_work <= '0;
         r_rnd  <= '0;
         r_k    <= '0;
         r_wrap <= 1'b0;
      end else if (i_init) begin
         r_init <= w_load;
         r_work <= w_load;
         r_rnd  <= '0;
         r_k    <= '0;
         r_wrap <= 1'b0;
      end else if (r_state == S_ROUND) begin
         r_work <= w_round;
         r_rnd  <= w_rnd_last ? '0 : r_rnd + 1'b1;
      end else if (r_state == S_ADD) begin
         r_work <= w_sum;
         r_k    <= '0;
      end else if (w_in_hs) begin
         r_k <= r_k + 4'd1;
         if (w_blk_end) begin
            r_init[12] <= w_ctr_inc;
            r_work     <= w_reload;
            r_wrap     <= r_wrap | (&r_init[12]);
         end
      end
   end

   // single registered output stage; holds while downstream stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
      end else if (i_init) begin
         r_out_valid <= 1'b0;
      end else if (w_in_hs) begin
         r_out_valid <= 1'b1;
         r_out_data  <= i_in_data ^ r_work[r_k];
         r_out_last  <= i_in_last;
      end else if (i_out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign o_in_ready  = w_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;
   assign o_out_last  = r_out_last;
   assign o_ctr_wrap  = r_wrap;
endmodule
